ps2_arrow_keys: RTL and testbench

//  Receives the PS/2 keyboard serial stream and decodes arrow-key make/break codes.

---
 rtl/ps2_pkg.sv | 35 +++
 rtl/ps2_arrow_keys_if.sv | 10 +
 rtl/ps2_rx.sv | 111 +++++++++++
 rtl/ps2_arrow_keys.sv | 65 ++++++
 tb/tb_ps2_arrow_keys.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - PS/2 scan-code constants, key bit indices and decoder state encoding
package ps2_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  localparam int KEY_UP    = 0;
  localparam int KEY_DOWN  = 1;
  localparam int KEY_LEFT  = 2;
  localparam int KEY_RIGHT = 3;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_EXT     = 2'd1;
  localparam logic [1:0] ST_EXT_BRK = 2'd2;
  localparam logic [1:0] ST_BRK     = 2'd3;

  // One-hot key mask for an arrow scan code; zero for anything else.
  function automatic logic [3:0] arrow_mask(input logic [7:0] code);
    logic [3:0] m;
    m = 4'b0000;
    case (code)
      SC_UP:    m[KEY_UP]    = 1'b1;
      SC_DOWN:  m[KEY_DOWN]  = 1'b1;
      SC_LEFT:  m[KEY_LEFT]  = 1'b1;
      SC_RIGHT: m[KEY_RIGHT] = 1'b1;
      default:  m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ps2_arrow_keys_if.sv
// rtl/ps2_arrow_keys_if.sv - PS/2 line inputs and held-key outputs of ps2_arrow_keys
interface ps2_arrow_keys_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [3:0] key;
  logic       frame_err;

  modport master (output ps2_clk, output ps2_data, input key, input frame_err);
  modport slave  (input ps2_clk, input ps2_data, output key, output frame_err);
endinterface

// File: rtl/ps2_rx.sv
// rtl/ps2_rx.sv - PS/2 device-to-host frame receiver with line conditioning and timeout
module ps2_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 65000
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic [7:0] o_byte,
  output logic       o_byte_valid,
  output logic       o_frame_err,
  output logic       o_abort
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]    w_in;
  logic [1:0]    r_meta, r_sync, r_filt;
  logic [FW-1:0] r_fcnt [2];
  logic          r_clk_d;
  logic          w_fall, w_bit;

  // Index 0 is the PS/2 clock line, index 1 the data line.
  assign w_in   = {i_ps2_data, i_ps2_clk};
  assign w_fall = r_clk_d & ~r_filt[0];
  assign w_bit  = r_filt[1];

  always_ff @(posedge pclk) begin
    if (rst) begin
      r_meta  <= 2'b11;
      r_sync  <= 2'b11;
      r_filt  <= 2'b11;
      r_clk_d <= 1'b1;
      for (int i = 0; i < 2; i++) r_fcnt[i] <= '0;
    end else begin
      r_meta  <= w_in;
      r_sync  <= r_meta;
      r_clk_d <= r_filt[0];
      for (int i = 0; i < 2; i++) begin
        if (r_sync[i] == r_filt[i]) begin
          r_fcnt[i] <= '0;
        end else if (r_fcnt[i] == FW'(FILTER_LEN - 1)) begin
          r_filt[i] <= r_sync[i];
          r_fcnt[i] <= '0;
        end else begin
          r_fcnt[i] <= r_fcnt[i] + 1'b1;
        end
      end
    end
  end

  logic [3:0]    r_cnt;
  logic [7:0]    r_shift;
  logic          r_par;
  logic [TW-1:0] r_timer;
  logic          r_valid, r_err, r_abort;

  always_ff @(posedge pclk) begin
    if (rst) begin
      r_cnt   <= 4'd0;
      r_shift <= 8'h00;
      r_par   <= 1'b0;
      r_timer <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_abort <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_abort <= 1'b0;
      if (w_fall) begin
        r_timer <= '0;
        if (r_cnt == 4'd0) begin
          if (w_bit) r_err <= 1'b1;
          else       r_cnt <= 4'd1;
        end else if (r_cnt <= 4'd8) begin
          r_shift <= {w_bit, r_shift[7:1]};
          r_cnt   <= r_cnt + 4'd1;
        end else if (r_cnt == 4'd9) begin
          r_par <= w_bit;
          r_cnt <= 4'd10;
        end else begin
          r_cnt <= 4'd0;
          if (w_bit && (^{r_shift, r_par})) begin
            r_valid <= 1'b1;
          end else begin
            r_err   <= 1'b1;
            r_abort <= 1'b1;
          end
        end
      end else if (r_cnt != 4'd0) begin
        // A stalled partial frame is dropped silently; the decoder is resynchronised.
        if (r_timer == TW'(TIMEOUT_CYCLES - 1)) begin
          r_cnt   <= 4'd0;
          r_timer <= '0;
          r_abort <= 1'b1;
        end else begin
          r_timer <= r_timer + 1'b1;
        end
      end
    end
  end

  assign o_byte       = r_shift;
  assign o_byte_valid = r_valid;
  assign o_frame_err  = r_err;
  assign o_abort      = r_abort;

endmodule

// File: rtl/ps2_arrow_keys.sv
// rtl/ps2_arrow_keys.sv - decodes PS/2 arrow-key make/break codes into a held-key bitmap
module ps2_arrow_keys
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 65000
) (
  input  logic            pclk,
  input  logic            rst,
  ps2_arrow_keys_if.slave bus
);

  logic [7:0] w_byte;
  logic       w_valid, w_err, w_abort;
  logic [1:0] r_state;
  logic [3:0] r_key;

  ps2_rx #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .pclk        (pclk),
    .rst         (rst),
    .i_ps2_clk   (bus.ps2_clk),
    .i_ps2_data  (bus.ps2_data),
    .o_byte      (w_byte),
    .o_byte_valid(w_valid),
    .o_frame_err (w_err),
    .o_abort     (w_abort)
  );

  always_ff @(posedge pclk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_key   <= 4'b0000;
    end else if (w_abort) begin
      r_state <= ST_IDLE;
    end else if (w_valid) begin
      case (r_state)
        ST_IDLE: begin
          if (w_byte == SC_EXT)      r_state <= ST_EXT;
          else if (w_byte == SC_BRK) r_state <= ST_BRK;
          else                       r_state <= ST_IDLE;
        end
        ST_EXT: begin
          if (w_byte == SC_BRK)      r_state <= ST_EXT_BRK;
          else if (w_byte == SC_EXT) r_state <= ST_EXT;
          else begin
            r_key   <= r_key | arrow_mask(w_byte);
            r_state <= ST_IDLE;
          end
        end
        ST_EXT_BRK: begin
          r_key   <= r_key & ~arrow_mask(w_byte);
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.key       = r_key;
  assign bus.frame_err = w_err;

endmodule

// File: tb/tb_ps2_arrow_keys.sv
// tb/tb_ps2_arrow_keys.sv - directed self-checking bench for ps2_arrow_keys
module tb_ps2_arrow_keys;
  import ps2_pkg::*;

  localparam int TO   = 600;
  localparam int HALF = 20;

  logic pclk = 1'b0;
  logic rst  = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   err_cnt = 0;
  int   e0;

  always #5 pclk = ~pclk;

  ps2_arrow_keys_if bus ();

  ps2_arrow_keys #(
    .FILTER_LEN    (8),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .pclk(pclk),
    .rst (rst),
    .bus (bus)
  );

  always @(negedge pclk) if (bus.frame_err === 1'b1) err_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge pclk);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par = 1'b0,
                            input bit timed = 1'b0, input logic [3:0] exp_key = 4'b0000,
                            input int nbits = 11);
    logic [10:0] bits;
    int w, n;
    bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      bus.ps2_data = bits[i];
      idle(HALF);
      bus.ps2_clk = 1'b0;
      if (timed && i == 10) begin
        w = 0;
        while (dut.u_rx.r_filt[0] !== 1'b0 && w < 40) begin
          @(negedge pclk);
          w++;
        end
        chk("stop_edge_seen", 32'(w < 40), 32'd1);
        n = 0;
        while (bus.key !== exp_key && n < 10) begin
          @(negedge pclk);
          n++;
        end
        chk("key_latency", 32'(n), 32'd2);
      end
      idle(HALF);
      bus.ps2_clk = 1'b1;
    end
    bus.ps2_data = 1'b1;
    idle(3 * HALF);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    rst = 1'b1;
    idle(4);
    rst = 1'b0;
    idle(2);
    chk("reset_key", bus.key, 4'b0000);
    chk("reset_frame_err", bus.frame_err, 1'b0);
    chk("reset_count", dut.u_rx.r_cnt, 4'd0);
    chk("reset_state", dut.r_state, ST_IDLE);

    // 1: UP make with latency check, then UP break
    send_frame(SC_EXT);
    send_frame(SC_UP, 1'b0, 1'b1, 4'b0001);
    chk("t1_up_make", bus.key, 4'b0001);
    chk("t1_no_err", err_cnt, 0);
    send_frame(SC_EXT); send_frame(SC_BRK); send_frame(SC_UP);
    chk("t1_up_break", bus.key, 4'b0000);

    // 2: rollover of LEFT and RIGHT
    send_frame(SC_EXT); send_frame(SC_LEFT);
    chk("t2_left", bus.key, 4'b0100);
    send_frame(SC_EXT); send_frame(SC_RIGHT);
    chk("t2_left_right", bus.key, 4'b1100);
    send_frame(SC_EXT); send_frame(SC_BRK); send_frame(SC_LEFT);
    chk("t2_left_break", bus.key, 4'b1000);
    send_frame(SC_EXT); send_frame(SC_BRK); send_frame(SC_RIGHT);
    chk("t2_right_break", bus.key, 4'b0000);

    // 3: bad parity on DOWN, then a good DOWN
    e0 = err_cnt;
    send_frame(SC_EXT);
    send_frame(SC_DOWN, 1'b1);
    chk("t3_err_pulses", err_cnt - e0, 1);
    chk("t3_key_kept", bus.key, 4'b0000);
    chk("t3_state_idle", dut.r_state, ST_IDLE);
    send_frame(SC_EXT); send_frame(SC_DOWN);
    chk("t3_down", bus.key, 4'b0010);

    // 4: non-extended traffic leaves key alone
    send_frame(SC_BRK); send_frame(SC_UP);
    chk("t4_plain_break", bus.key, 4'b0010);
    send_frame(8'h1C); send_frame(8'hAA);
    chk("t4_other_codes", bus.key, 4'b0010);
    chk("t4_state_idle", dut.r_state, ST_IDLE);
    send_frame(SC_UP);
    chk("t4_bare_up", bus.key, 4'b0010);
    send_frame(SC_EXT); send_frame(SC_BRK); send_frame(SC_DOWN);
    chk("t4_down_break", bus.key, 4'b0000);

    // 5: partial frame then timeout
    e0 = err_cnt;
    send_frame(8'h55, 1'b0, 1'b0, 4'b0000, 6);
    chk("t5_partial_count", dut.u_rx.r_cnt, 4'd6);
    idle(TO + 10);
    chk("t5_timeout_count", dut.u_rx.r_cnt, 4'd0);
    chk("t5_no_err", err_cnt - e0, 0);
    chk("t5_key_kept", bus.key, 4'b0000);
    send_frame(SC_EXT); send_frame(SC_UP);
    chk("t5_up", bus.key, 4'b0001);

    // 6: typematic repeat, then reset mid-frame
    for (int r = 0; r < 3; r++) begin
      send_frame(SC_EXT); send_frame(SC_UP);
      chk("t6_typematic", bus.key, 4'b0001);
    end
    send_frame(SC_EXT, 1'b0, 1'b0, 4'b0000, 4);
    rst = 1'b1;
    @(negedge pclk);
    chk("t6_rst_key", bus.key, 4'b0000);
    chk("t6_rst_count", dut.u_rx.r_cnt, 4'd0);
    chk("t6_rst_state", dut.r_state, ST_IDLE);
    rst = 1'b0;
    idle(50);
    send_frame(SC_EXT); send_frame(SC_RIGHT);
    chk("t6_right", bus.key, 4'b1000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
